// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg: shared bus widths, write-enable levels and default starvation limit
package reg_write_arbiter_pkg;
    localparam int   ADDR_W           = 5;
    localparam int   DATA_W           = 32;
    localparam logic WRITE_ENABLE     = 1'b1;
    localparam logic WRITE_DISABLE    = 1'b0;
    localparam int   STARVE_LIMIT_DEF = 4;
    localparam int   CNT_W_DEF        = 3;
endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: one-entry writeback buffer; refills in the same edge its entry is granted out
module wb_hold_slot
    import reg_write_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);
    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    assign o_ready = !r_full || i_grant;
    assign o_full  = r_full;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_grant) begin
            r_full <= 1'b0;
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between the WB stage (A) and the
// multi-cycle unit (B), with $zero suppression, collision ordering and a starvation bound for B.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              w_write_reg,
    output logic [ADDR_W-1:0] reg_des,
    output logic [DATA_W-1:0] reg_data,
    output logic              stall_o
);
    logic              w_a_full, w_b_full;
    logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_sel_addr;
    logic [DATA_W-1:0] w_a_data, w_b_data;
    logic              w_grant_a, w_grant_b, w_collide, w_starved;
    logic [CNT_W-1:0]  r_starve;
    logic              r_we;
    logic [ADDR_W-1:0] r_des;
    logic [DATA_W-1:0] r_data;

    wb_hold_slot u_slot_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .i_addr(a_addr), .i_data(a_data),
        .i_grant(w_grant_a), .o_ready(a_ready), .o_full(w_a_full), .o_addr(w_a_addr), .o_data(w_a_data)
    );

    wb_hold_slot u_slot_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .i_addr(b_addr), .i_data(b_data),
        .i_grant(w_grant_b), .o_ready(b_ready), .o_full(w_b_full), .o_addr(w_b_addr), .o_data(w_b_data)
    );

    // B is older in program order, so it wins a same-register collision
    assign w_collide  = w_a_full && w_b_full && (w_a_addr == w_b_addr) && (w_a_addr != '0);
    assign w_starved  = r_starve == CNT_W'(STARVE_LIMIT);
    assign w_grant_b  = w_b_full && (!w_a_full || w_collide || w_starved);
    assign w_grant_a  = w_a_full && !w_grant_b;
    assign w_sel_addr = w_grant_b ? w_b_addr : w_a_addr;
    assign stall_o    = a_valid && !a_ready;

    assign w_write_reg = r_we;
    assign reg_des     = r_des;
    assign reg_data    = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve <= '0;
        else if (!w_b_full || w_grant_b)
            r_starve <= '0;
        else if (!w_starved)
            r_starve <= r_starve + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= WRITE_DISABLE;
            r_des  <= '0;
            r_data <= '0;
        end else if (w_grant_a || w_grant_b) begin
            r_we   <= (w_sel_addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
            r_des  <= w_sel_addr;
            r_data <= w_grant_b ? w_b_data : w_a_data;
        end else begin
            r_we   <= WRITE_DISABLE;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed + random stimulus, transaction-level model feeding a scoreboard
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, w_write_reg, stall_o;
    logic [4:0]  reg_des;
    logic [31:0] reg_data;

    always #5 clk = ~clk;

    reg_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .w_write_reg(w_write_reg), .reg_des(reg_des), .reg_data(reg_data), .stall_o(stall_o)
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;

    ent_t ma[$], mb[$];
    wr_t  exp_q[$];
    int   starve = 0, cyc = 0, tests = 0, fails = 0, stalls = 0, pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a write is due exactly on the cycle the model scheduled it
    always @(negedge clk) begin
        bit due;
        if (rst_n) begin
            due = exp_q.size() > 0 && exp_q[0].cyc == cyc;
            chk("w_write_reg", {31'b0, w_write_reg}, {31'b0, due});
            if (w_write_reg) pulses++;
            if (due) begin
                chk("reg_des", {27'b0, reg_des}, {27'b0, exp_q[0].addr});
                chk("reg_data", reg_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle of requests and advance the reference model to the next edge
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        bit af, bf, coll, ga, gb, ar, br;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        af   = ma.size() > 0;
        bf   = mb.size() > 0;
        coll = af && bf && ma[0].addr == mb[0].addr && ma[0].addr != 0;
        gb   = bf && (!af || coll || starve == STARVE_LIMIT_DEF);
        ga   = af && !gb;
        ar   = !af || ga;
        br   = !bf || gb;
        chk("a_ready", {31'b0, a_ready}, {31'b0, ar});
        chk("b_ready", {31'b0, b_ready}, {31'b0, br});
        chk("stall_o", {31'b0, stall_o}, {31'b0, av && !ar});
        if (stall_o) stalls++;
        if (ga) begin
            if (ma[0].addr != 0) exp_q.push_back('{ma[0].addr, ma[0].data, cyc + 1});
            void'(ma.pop_front());
        end
        if (gb) begin
            if (mb[0].addr != 0) exp_q.push_back('{mb[0].addr, mb[0].data, cyc + 1});
            void'(mb.pop_front());
        end
        starve = (!bf || gb) ? 0 : (starve < STARVE_LIMIT_DEF ? starve + 1 : starve);
        if (av && ar) ma.push_back('{aa, ad});
        if (bv && br) mb.push_back('{ba, bd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_we", {31'b0, w_write_reg}, 32'h0);
        chk("rst_des", {27'b0, reg_des}, 32'h0);
        chk("rst_data", reg_data, 32'h0);
        chk("rst_a_ready", {31'b0, a_ready}, 32'h1);
        chk("rst_b_ready", {31'b0, b_ready}, 32'h1);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        step(1'b1, 5'h11, 32'h1324, 1'b0, 5'h0, 32'h0);
        idle(3);

        step(1'b1, 5'h12, 32'h1212, 1'b1, 5'h12, 32'h1242);
        idle(3);

        stalls = 0;
        step(1'b1, 5'h10, 32'hA000, 1'b1, 5'h03, 32'hBEEF);
        for (int i = 1; i <= 8; i++) step(1'b1, 5'(5'h10 + i), 32'hA000 + i, 1'b0, 5'h0, 32'h0);
        idle(4);
        chk("starve_stalls", stalls, 32'd1);

        step(1'b1, 5'h00, 32'hFFFF_FFFF, 1'b0, 5'h0, 32'h0);
        idle(3);

        idle(1);
        pulses = 0;
        stalls = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 1), 32'hC000 + i, 1'b0, 5'h0, 32'h0);
        idle(3);
        chk("b2b_pulses", pulses, 32'd8);
        chk("b2b_stalls", stalls, 32'd0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        idle(6);

        step(1'b1, 5'h05, 32'h0505, 1'b1, 5'h06, 32'h0606);
        step(1'b1, 5'h07, 32'h0707, 1'b0, 5'h0, 32'h0);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        chk("pre_rst_b_full", {31'b0, b_ready}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'b0, w_write_reg}, 32'h0);
        chk("mid_rst_des", {27'b0, reg_des}, 32'h0);
        chk("mid_rst_data", reg_data, 32'h0);
        chk("mid_rst_a_ready", {31'b0, a_ready}, 32'h1);
        chk("mid_rst_b_ready", {31'b0, b_ready}, 32'h1);
        ma.delete();
        mb.delete();
        exp_q.delete();
        starve = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
